register_file: RTL and testbench



---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_read_port.sv | 39 +++
 rtl/register_file.sv | 64 ++++++
 tb/tb_register_file.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and types for the MIPS register file
// Optional build macro used by this slice: REGFILE_WRITE_BYPASS_EN
package regfile_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ADDR_WIDTH = 5;
    localparam int NUM_REGS           = 2 ** DEFAULT_ADDR_WIDTH;
    localparam int unsigned ZERO_REG  = 0;

    typedef logic [DEFAULT_ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [DEFAULT_DATA_WIDTH-1:0] reg_data_t;

endpackage

// File: rtl/regfile_read_port.sv
// rtl/regfile_read_port.sv - combinational read mux with zero-register masking
// Ports: readReg (index), regs (storage array), writeActive/writeReg/writeData
// (current-cycle write, used only for forwarding), readData (result).
// Macro: REGFILE_WRITE_BYPASS_EN enables write-first forwarding.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic [ADDR_WIDTH-1:0] readReg,
    input  logic [DATA_WIDTH-1:0] regs [2**ADDR_WIDTH],
    input  logic                  writeActive,
    input  logic [ADDR_WIDTH-1:0] writeReg,
    input  logic [DATA_WIDTH-1:0] writeData,
    output logic [DATA_WIDTH-1:0] readData
);

`ifndef REGFILE_WRITE_BYPASS_EN
    // Write-port signals only matter when forwarding is built in.
    logic unusedWriteSignals;
    assign unusedWriteSignals = ^{writeActive, writeReg, writeData};
`endif

    always_comb begin
        readData = regs[readReg];
`ifdef REGFILE_WRITE_BYPASS_EN
        // writeActive already excludes reset and index 0.
        if (writeActive && (writeReg == readReg)) begin
            readData = writeData;
        end
`endif
        // Index 0 is masked here rather than relying on stored contents.
        if (readReg == ADDR_WIDTH'(ZERO_REG)) begin
            readData = '0;
        end
    end

endmodule

// File: rtl/register_file.sv
// rtl/register_file.sv - 32x32 MIPS register file, two async reads, one sync write
// Ports: clk, reset (sync, active-high), RegWrite, WriteReg, WriteData (write port);
// ReadReg1/ReadData1 and ReadReg2/ReadData2 (combinational read ports).
// Macro: REGFILE_WRITE_BYPASS_EN enables same-cycle write forwarding to reads.
module register_file
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  RegWrite,
    input  logic [ADDR_WIDTH-1:0] ReadReg1,
    input  logic [ADDR_WIDTH-1:0] ReadReg2,
    input  logic [ADDR_WIDTH-1:0] WriteReg,
    input  logic [DATA_WIDTH-1:0] WriteData,
    output logic [DATA_WIDTH-1:0] ReadData1,
    output logic [DATA_WIDTH-1:0] ReadData2
);

    localparam int NUM_ENTRIES = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [NUM_ENTRIES];
    logic                  writeActive;

    // Reset wins over a simultaneous write; index 0 is never written.
    assign writeActive = RegWrite && !reset && (WriteReg != ADDR_WIDTH'(ZERO_REG));

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                regs[i] <= '0;
            end
        end else if (writeActive) begin
            regs[WriteReg] <= WriteData;
        end
    end

    regfile_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) readPort1 (
        .readReg     (ReadReg1),
        .regs        (regs),
        .writeActive (writeActive),
        .writeReg    (WriteReg),
        .writeData   (WriteData),
        .readData    (ReadData1)
    );

    regfile_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) readPort2 (
        .readReg     (ReadReg2),
        .regs        (regs),
        .writeActive (writeActive),
        .writeReg    (WriteReg),
        .writeData   (WriteData),
        .readData    (ReadData2)
    );

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - self-checking bench for register_file
module tb_register_file;
    import regfile_pkg::*;

    logic      clk = 1'b0;
    logic      reset = 1'b1;
    logic      RegWrite = 1'b0;
    reg_addr_t ReadReg1 = '0;
    reg_addr_t ReadReg2 = '0;
    reg_addr_t WriteReg = '0;
    reg_data_t WriteData = '0;
    reg_data_t ReadData1;
    reg_data_t ReadData2;

    int tests = 0;
    int fails = 0;

    reg_data_t model [NUM_REGS];
    bit        modelValid = 1'b0;

    register_file dut (
        .clk       (clk),
        .reset     (reset),
        .RegWrite  (RegWrite),
        .ReadReg1  (ReadReg1),
        .ReadReg2  (ReadReg2),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .ReadData1 (ReadData1),
        .ReadData2 (ReadData2)
    );

    always #5 clk = ~clk;

    // Reference: a plain array of register values updated from the rules.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
            modelValid = 1'b1;
        end else if (RegWrite && WriteReg != 0) begin
            model[WriteReg] = WriteData;
        end
    end

    function automatic reg_data_t expectedRead(input reg_addr_t addr);
        if (addr == 0) return '0;
`ifdef REGFILE_WRITE_BYPASS_EN
        if (RegWrite && !reset && WriteReg != 0 && WriteReg == addr) return WriteData;
`endif
        return model[addr];
    endfunction

    task automatic check(input string name, input reg_data_t actual, input reg_data_t required);
        tests++;
        if (actual !== required) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, required);
        end
    endtask

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (modelValid) begin
            check("model_port1", ReadData1, expectedRead(ReadReg1));
            check("model_port2", ReadData2, expectedRead(ReadReg2));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reg_data_t v;

        // Reset then read.
        step();
        reset = 1'b0;
        ReadReg1 = 5'd5;
        ReadReg2 = 5'd2;
        #1;
        check("reset_rd1", ReadData1, 32'd0);
        check("reset_rd2", ReadData2, 32'd0);

        // Basic write, held for 10 edges.
        RegWrite = 1'b1;
        WriteReg = 5'd8;
        WriteData = 32'd216;
        repeat (10) step();
        RegWrite = 1'b0;
        ReadReg1 = 5'd5;
        ReadReg2 = 5'd8;
        #1;
        check("basic_rd5", ReadData1, 32'd0);
        check("basic_rd8", ReadData2, 32'd216);
        repeat (3) step();
        check("persist_rd8", ReadData2, 32'd216);

        // Write disabled.
        WriteReg = 5'd9;
        WriteData = 32'hDEADBEEF;
        step();
        ReadReg1 = 5'd9;
        #1;
        check("wr_disabled", ReadData1, 32'd0);

        // Zero register.
        RegWrite = 1'b1;
        WriteReg = 5'd0;
        WriteData = 32'hFFFFFFFF;
        step();
        RegWrite = 1'b0;
        ReadReg1 = 5'd0;
        ReadReg2 = 5'd0;
        #1;
        check("zero_rd1", ReadData1, 32'd0);
        check("zero_rd2", ReadData2, 32'd0);

        // Full range writes i*3.
        RegWrite = 1'b1;
        for (int i = 1; i < 32; i++) begin
            WriteReg = 5'(i);
            WriteData = 32'(i * 3);
            step();
        end
        RegWrite = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ReadReg1 = 5'(i);
            ReadReg2 = 5'(31 - i);
            #1;
            check("range_p1", ReadData1, 32'(i * 3));
            check("range_p2", ReadData2, (i == 31) ? 32'd0 : 32'((31 - i) * 3));
            ReadReg2 = 5'(i);
            #1;
            check("same_index", ReadData2, ReadData1);
        end

        // Read-during-write on reg 8.
        RegWrite = 1'b1;
        WriteReg = 5'd8;
        WriteData = 32'd216;
        step();
        WriteData = 32'd500;
        ReadReg1 = 5'd8;
        ReadReg2 = 5'd8;
        #1;
`ifdef REGFILE_WRITE_BYPASS_EN
        check("rdw_before", ReadData1, 32'd500);
`else
        check("rdw_before", ReadData1, 32'd216);
`endif
        step();
        RegWrite = 1'b0;
        #1;
        check("rdw_after", ReadData1, 32'd500);

        // Reset priority over a simultaneous write.
        reset = 1'b1;
        RegWrite = 1'b1;
        WriteData = 32'd777;
        #1;
        check("rst_pending", ReadData1, 32'd500);
        step();
        reset = 1'b0;
        RegWrite = 1'b0;
        #1;
        check("rst_priority", ReadData1, 32'd0);

        // Randomized traffic; the negedge comparator checks every cycle.
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 99) == 0);
            RegWrite = $urandom_range(0, 2) != 0;
            WriteReg = 5'($urandom_range(0, 31));
            v = $urandom;
            WriteData = v;
            ReadReg1 = ($urandom_range(0, 3) == 0) ? WriteReg : 5'($urandom_range(0, 31));
            ReadReg2 = ($urandom_range(0, 7) == 0) ? ReadReg1 : 5'($urandom_range(0, 31));
            step();
        end
        reset = 1'b0;
        RegWrite = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
